// File: rtl/o2_router.sv
// o2_router: one-input, two-output packet splitter. Whole packets are steered by
// a destination bit in the head flit into per-port show-ahead FIFOs.

module o2_router_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [15:0] i_data,
  input  logic        i_pop,
  output logic [15:0] o_data,
  output logic        o_full,
  output logic        o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        w_push, w_pop;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

module o2_router #(
  parameter int DEPTH    = 4,
  parameter int DEST_BIT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_data,
  input  logic        input_req,
  output logic        input_bussy,
  output logic [15:0] output_data1,
  output logic        output_req1,
  input  logic        output_bussy1,
  output logic [15:0] output_data2,
  output logic        output_req2,
  input  logic        output_bussy2,
  output logic        route_err
);
  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t r_state, w_state_nxt;
  logic   r_route_sel;
  logic   r_route_err;

  logic [1:0][15:0] w_fifo_data;
  logic [1:0]       w_full, w_empty, w_push, w_pop, w_out_bussy;
  logic [2:0]       w_type;
  logic             w_is_head, w_is_tail, w_target, w_xfer, w_err_set;

  assign w_type      = input_data[15:13];
  assign w_is_head   = (w_type == 3'b000) || (w_type == 3'b001);
  assign w_is_tail   = (w_type == 3'b111);
  assign w_out_bussy = {output_bussy2, output_bussy1};

  always_comb begin
    w_state_nxt = r_state;
    w_push      = '0;
    w_err_set   = 1'b0;
    w_target    = r_route_sel;
    input_bussy = 1'b0;
    w_xfer      = 1'b0;
    if (r_state == S_IDLE) begin
      w_target = input_data[DEST_BIT];
      // Stray non-head flits are swallowed so a broken stream cannot wedge the link.
      if (input_req && w_is_head) begin
        input_bussy = w_full[w_target];
        w_xfer      = ~w_full[w_target];
        w_push[w_target] = w_xfer;
        if (w_xfer) w_state_nxt = S_PKT;
      end else if (input_req) begin
        w_err_set = 1'b1;
      end
    end else begin
      input_bussy = input_req & w_full[r_route_sel];
      w_xfer      = input_req & ~w_full[r_route_sel];
      w_push[r_route_sel] = w_xfer;
      if (w_xfer && w_is_tail) w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_route_sel <= 1'b0;
      r_route_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_xfer) r_route_sel <= w_target;
      if (w_err_set) r_route_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_port
    assign w_pop[k] = ~w_empty[k] & ~w_out_bussy[k];
    o2_router_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_push[k]),
      .i_data (input_data),
      .i_pop  (w_pop[k]),
      .o_data (w_fifo_data[k]),
      .o_full (w_full[k]),
      .o_empty(w_empty[k])
    );
  end

  assign output_data1 = w_fifo_data[0];
  assign output_data2 = w_fifo_data[1];
  assign output_req1  = ~w_empty[0];
  assign output_req2  = ~w_empty[1];
  assign route_err    = r_route_err;
endmodule
